// File: rtl/a2d_spi_resp.sv
// SPI responder standing in for an 8-channel, 12-bit A2D converter.
// Returns the channel selected by the previous valid frame while receiving the next command.
module a2d_spi_resp #(
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int NUM_CH     = 8,
  parameter int RESET_CH   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        SS_n,
  input  logic                        SCLK,
  input  logic                        MOSI,
  input  logic [NUM_CH*DATA_BITS-1:0] analog_vals,
  output logic                        MISO,
  output logic [2:0]                  chnnl_cmd,
  output logic                        frame_done,
  output logic                        frame_err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_MAX  = 5'(FRAME_BITS + 1);

  // [0],[1] synchronise the pin, [2] is the edge-detect history flop
  logic [2:0] r_ss_pipe;
  logic [2:0] r_sclk_pipe;
  logic [2:0] r_mosi_pipe;

  logic [0:0]            r_state;
  logic [FRAME_BITS-1:0] r_tx_shft;
  logic [FRAME_BITS-2:0] r_rx_shft;
  logic [4:0]            r_bit_cnt;
  logic [2:0]            r_chnl;
  logic                  r_done;
  logic                  r_err;

  logic                 w_ss_fall;
  logic                 w_ss_rise;
  logic                 w_sclk_rise;
  logic                 w_sclk_fall;
  logic                 w_mosi;
  logic [DATA_BITS-1:0] w_sel_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_pipe   <= 3'b111;
      r_sclk_pipe <= 3'b000;
      r_mosi_pipe <= 3'b000;
    end else begin
      r_ss_pipe   <= {r_ss_pipe[1:0], SS_n};
      r_sclk_pipe <= {r_sclk_pipe[1:0], SCLK};
      r_mosi_pipe <= {r_mosi_pipe[1:0], MOSI};
    end
  end

  assign w_ss_fall   =  r_ss_pipe[2]   & ~r_ss_pipe[1];
  assign w_ss_rise   = ~r_ss_pipe[2]   &  r_ss_pipe[1];
  assign w_sclk_rise = ~r_sclk_pipe[2] &  r_sclk_pipe[1];
  assign w_sclk_fall =  r_sclk_pipe[2] & ~r_sclk_pipe[1];
  assign w_mosi      =  r_mosi_pipe[2];

  assign w_sel_val = analog_vals[32'(r_chnl) * DATA_BITS +: DATA_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tx_shft <= '0;
      r_rx_shft <= '0;
      r_bit_cnt <= '0;
      r_chnl    <= 3'(RESET_CH);
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_state   <= SHIFT;
            r_tx_shft <= {{(FRAME_BITS-DATA_BITS){1'b0}}, w_sel_val};
            r_rx_shft <= '0;
            r_bit_cnt <= '0;
          end
        end
        default: begin
          // Slave-select release takes priority over any SCLK edge seen in the same cycle
          if (w_ss_rise) begin
            r_state   <= IDLE;
            r_tx_shft <= '0;
            if (r_bit_cnt == CNT_FULL) begin
              r_chnl <= r_rx_shft[13:11];
              r_done <= 1'b1;
            end else begin
              r_err  <= 1'b1;
            end
          end else if (w_sclk_rise) begin
            r_rx_shft <= {r_rx_shft[FRAME_BITS-3:0], w_mosi};
            if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + 5'd1;
          end else if (w_sclk_fall && (r_bit_cnt != 5'd0)) begin
            r_tx_shft <= {r_tx_shft[FRAME_BITS-2:0], 1'b0};
          end
        end
      endcase
    end
  end

  // tx_shft is cleared whenever the frame ends, so its MSB is already 0 outside SHIFT
  assign MISO       = r_tx_shft[FRAME_BITS-1];
  assign chnnl_cmd  = r_chnl;
  assign frame_done = r_done;
  assign frame_err  = r_err;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Randomized self-checking bench for a2d_spi_resp against a frame-level model:
// each valid frame returns the value of the channel commanded by the previous valid frame.
module tb_a2d_spi_resp;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic [95:0] analog_vals;
  logic        MISO;
  logic [2:0]  chnnl_cmd;
  logic        frame_done;
  logic        frame_err;

  a2d_spi_resp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SS_n        (SS_n),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .analog_vals (analog_vals),
    .MISO        (MISO),
    .chnnl_cmd   (chnnl_cmd),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_err    = 0;

  logic [11:0] ch_val [8];
  logic [2:0]  model_ch;

  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_analog();
    for (int k = 0; k < 8; k++) analog_vals[k*12 +: 12] = ch_val[k];
  endtask

  task automatic sclk_cycle(input logic mosi_bit, output logic miso_bit);
    MOSI = mosi_bit;
    wait_clk(6);
    @(negedge clk);
    miso_bit = MISO;
    wait_clk(1);
    SCLK = 1'b1;
    wait_clk(6);
    SCLK = 1'b0;
  endtask

  // One SPI frame with nrise SCLK rises; optional SCLK edge coincident with SS_n release
  task automatic do_frame(input logic [15:0] cmd, input int nrise, input bit simul,
                          input bit glitch, output logic [15:0] miso_word);
    logic b;
    miso_word = '0;
    SS_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nrise; i++) begin
      if (glitch && i == 4) begin
        for (int k = 0; k < 8; k++) ch_val[k] = 12'($urandom);
        load_analog();
      end
      sclk_cycle((i < 16) ? cmd[15-i] : 1'b0, b);
      if (i < 16) miso_word[15-i] = b;
    end
    wait_clk(6);
    if (simul) begin
      SCLK = 1'b1;
      SS_n = 1'b1;
      wait_clk(6);
      SCLK = 1'b0;
    end else begin
      SS_n = 1'b1;
    end
    wait_clk(8);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] cmd, input int nrise,
                           input bit simul, input bit glitch);
    logic [15:0] word;
    logic [15:0] exp_word;
    int d0, e0;
    bit full;
    exp_word = {4'b0, ch_val[model_ch]};
    d0 = n_done;
    e0 = n_err;
    do_frame(cmd, nrise, simul, glitch, word);
    full = (nrise == 16);
    if (full) model_ch = cmd[13:11];
    if (nrise >= 16) check({tag, "_miso"}, 32'(word), 32'(exp_word));
    check({tag, "_done"}, 32'(n_done - d0), full ? 32'd1 : 32'd0);
    check({tag, "_err"},  32'(n_err - e0),  full ? 32'd0 : 32'd1);
    check({tag, "_cmd"},  32'(chnnl_cmd), 32'(model_ch));
    $display("frame %s cmd=0x%04h rises=%0d miso=0x%04h exp=0x%04h ch=%0d",
             tag, cmd, nrise, word, exp_word, chnnl_cmd);
  endtask

  initial begin
    logic b;
    int nr;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b0;
    MOSI  = 1'b0;
    for (int k = 0; k < 8; k++) ch_val[k] = 12'h000;
    load_analog();
    model_ch = 3'd0;

    // Reset behaviour
    wait_clk(5);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_cmd", 32'(chnnl_cmd), 32'd0);
    rst_n = 1'b1;
    wait_clk(10);
    check("post_rst_miso", 32'(MISO), 32'd0);
    check("post_rst_pulses", 32'(n_done + n_err), 32'd0);

    // Directed pipelined pair
    ch_val[0] = 12'hABC;
    ch_val[3] = 12'h5A5;
    load_analog();
    run_frame("dir0", 16'h1800, 16, 1'b0, 1'b0);
    run_frame("dir1", 16'h0000, 16, 1'b0, 1'b0);

    // Round robin ch0..7 then ch0
    for (int k = 0; k < 8; k++) ch_val[k] = 12'(k * 12'h111);
    load_analog();
    for (int k = 0; k < 9; k++)
      run_frame($sformatf("rr%0d", k), {2'b00, 3'(k % 8), 11'h5A3}, 16, 1'b0, 1'b0);

    // Short frame, overrun, coincident SCLK edge with SS_n release
    run_frame("short9", 16'h3800, 9, 1'b0, 1'b0);
    run_frame("after_short", 16'h1000, 16, 1'b0, 1'b0);
    run_frame("over17", 16'h2800, 17, 1'b0, 1'b0);
    run_frame("simul", 16'h2000, 16, 1'b1, 1'b0);
    run_frame("glitch", 16'h0800, 16, 1'b0, 1'b1);

    // Randomized frames
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 9) < 7) nr = 16;
      else if ($urandom_range(0, 1) == 0) nr = $urandom_range(1, 15);
      else nr = $urandom_range(17, 20);
      run_frame($sformatf("rnd%0d", t), 16'($urandom), nr,
                (nr == 16) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
    end

    // Reset mid-frame: MISO forced low immediately, channel back to RESET_CH
    ch_val[model_ch] = 12'hFFF;
    load_analog();
    SS_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 6; i++) sclk_cycle(1'b0, b);
    wait_clk(6);
    check("pre_rst_miso", 32'(MISO), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_miso", 32'(MISO), 32'd0);
    check("midrst_cmd", 32'(chnnl_cmd), 32'd0);
    SS_n = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    model_ch = 3'd0;
    ch_val[0] = 12'h3C7;
    load_analog();
    wait_clk(8);
    check("midrst_pulses", 32'(n_done + n_err), 32'(n_done + n_err));
    run_frame("after_rst", 16'h1800, 16, 1'b0, 1'b0);

    // SS_n held low through reset release gives a partial frame
    SS_n = 1'b0;
    rst_n = 1'b0;
    wait_clk(4);
    model_ch = 3'd0;
    nr = n_err;
    rst_n = 1'b1;
    wait_clk(8);
    SS_n = 1'b1;
    wait_clk(8);
    check("ss_low_rst_err", 32'(n_err - nr), 32'd1);
    check("ss_low_rst_cmd", 32'(chnnl_cmd), 32'd0);
    run_frame("final", 16'h0000, 16, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
